// File: rtl/hssim_ctrl.sv
// hssim_ctrl: frame sequencer for the HSSIM edge-similarity pipeline.
// Accepts one frame of input/reference beats, drives the HSSIM stall input,
// tracks which pipeline stages hold real data with a token shift register, and
// pads with zeros after the last beat so the final results drain out.
// Optional feature: define HSSIM_CTRL_LAST_CHECK_EN to flag s_last mismatches
// in last_err; otherwise s_last is ignored and last_err is tied low.
module hssim_ctrl #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int PIPE_LATENCY    = 10
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic                                          s_valid,
    input  logic                                          s_last,
    output logic                                          s_ready,
    output logic                                          hssim_stall,
    output logic                                          hssim_in_sel,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic                                          m_last,
    output logic [$clog2(IMAGE_DIM/PIXELS_PER_BEAT)-1:0]  col_idx,
    output logic [$clog2(IMAGE_DIM)-1:0]                  row_idx,
    output logic                                          busy,
    output logic                                          frame_done,
    output logic                                          last_err
);

    localparam int COLS  = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int BEATS = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(IMAGE_DIM);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                  state, state_nxt;
    logic [PIPE_LATENCY-1:0] token;
    logic [CNT_W-1:0]        in_cnt, out_cnt;
    logic                    blocked, adv, m_fire, in_last;

    assign m_valid     = token[PIPE_LATENCY-1];
    assign m_fire      = m_valid & m_ready;
    assign blocked     = m_valid & ~m_ready;
    assign in_last     = (in_cnt == CNT_W'(BEATS - 1));
    assign m_last      = m_valid & (out_cnt == CNT_W'(BEATS - 1));
    assign hssim_stall = ~adv;
    assign busy        = (state != IDLE);
    assign frame_done  = (state == DONE);

    // Next-state and advance decode; a blocked output freezes the whole pipe.
    always_comb begin
        state_nxt    = state;
        adv          = 1'b0;
        s_ready      = 1'b0;
        hssim_in_sel = 1'b1;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                s_ready = ~blocked;
                adv     = s_valid & ~blocked;
                if (adv && in_last) state_nxt = FLUSH;
            end
            FLUSH: begin
                hssim_in_sel = 1'b0;
                adv          = ~blocked & (|token);
                if (m_fire && m_last) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Tokens, beat/result counters and frame position; cleared on reset or start.
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && start)) begin
            token   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            col_idx <= '0;
            row_idx <= '0;
        end else begin
            // A result taken while the pipe holds still must not be shown again.
            if (adv)         token <= {token[PIPE_LATENCY-2:0], (state == RUN)};
            else if (m_fire) token[PIPE_LATENCY-1] <= 1'b0;
            if (m_fire) out_cnt <= out_cnt + CNT_W'(1);
            if (adv && state == RUN) begin
                in_cnt <= in_cnt + CNT_W'(1);
                if (col_idx == COL_W'(COLS - 1)) begin
                    col_idx <= '0;
                    row_idx <= row_idx + ROW_W'(1);
                end else begin
                    col_idx <= col_idx + COL_W'(1);
                end
            end
        end
    end

`ifdef HSSIM_CTRL_LAST_CHECK_EN
    // Sticky flag: upstream end-of-frame marker disagrees with the beat count.
    always_ff @(posedge clk) begin
        if (reset)                                            last_err <= 1'b0;
        else if (state == RUN && adv && (s_last != in_last)) last_err <= 1'b1;
    end
`else
    wire unused_s_last = s_last;
    assign last_err = 1'b0;
`endif

endmodule

// File: doc/hssim_ctrl.md
# hssim_ctrl

Frame sequencer for the HSSIM edge-similarity pipeline. It accepts one frame of paired input/reference beats over a valid/ready stream and drives the pipeline's `stall` input. It tracks which pipeline stages hold real data, and after the last input beat it pushes zero padding so the final results drain out. It emits `m_valid`/`m_last` aligned with the HSSIM `numr_out`/`denr_out` and applies downstream backpressure by stalling the whole pipeline.

## Interface
- `PIXELS_PER_BEAT`, 16, pixels per beat.
- `IMAGE_DIM`, 512, frame width and height in pixels.
- `PIPE_LATENCY`, 10, number of non-stalled cycles from a beat at the HSSIM input to its result on `numr_out`/`denr_out`; must be ≥ 2.
- `BEATS`, derived, `IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse that begins a frame; honoured only in IDLE.
- `s_valid`  in  1  an input/reference beat pair is present.
- `s_last`  in  1  upstream end-of-frame marker.
- `s_ready`  out  1  the beat pair is consumed this cycle.
- `hssim_stall`  out  1  drives the HSSIM `stall` input.
- `hssim_in_sel`  out  1  selects frame data (1) or zero padding (0) into HSSIM.
- `m_valid`  out  1  `numr_out`/`denr_out` hold a valid result.
- `m_ready`  in  1  downstream accepts the result.
- `m_last`  out  1  the current result is the final one of the frame.
- `col_idx`  out  clog2(IMAGE_DIM/PIXELS_PER_BEAT)  beat column of the next input beat.
- `row_idx`  out  clog2(IMAGE_DIM)  row of the next input beat.
- `busy`  out  1  high whenever the state is not IDLE.
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `last_err`  out  1  sticky `s_last` mismatch flag.

## Operation
- Definitions:
  - `blocked = m_valid & ~m_ready`.
  - `adv` is the HSSIM advance, and `hssim_stall = ~adv`.
  - `m_fire = m_valid & m_ready`.
- States:
  - **IDLE**: `adv=0`, `s_ready=0`. On `start`, clear all counters and go to RUN.
  - **RUN**: `s_ready = ~blocked`, `adv = s_valid & ~blocked`, `hssim_in_sel=1`.
    - Each `adv` increments `in_cnt` and advances `col_idx`/`row_idx` (column wraps at `IMAGE_DIM/PIXELS_PER_BEAT-1` and increments the row).
    - An `adv` with `in_cnt==BEATS-1` goes to FLUSH.
  - **FLUSH**: `s_ready=0`, `hssim_in_sel=0`, `adv = ~blocked & (token != 0)`. An `m_fire` with `m_last` goes to DONE.
  - **DONE**: `frame_done=1` for this single cycle, then go to IDLE.
- Token shift register, `PIPE_LATENCY` bits:
  - On `adv`, shift in 1 in RUN and 0 in FLUSH.
  - `m_valid = token[PIPE_LATENCY-1]`.
  - On an `m_fire` cycle without `adv`, clear `token[PIPE_LATENCY-1]` so no result is presented twice.
- Output count:
  - `out_cnt` increments on `m_fire`.
  - `m_last = m_valid & (out_cnt == BEATS-1)`.
- Counter widths are `clog2(BEATS)+1`; counters never wrap within a frame.
- `start` outside IDLE is ignored.
- Reset mid-frame:
  - Next cycle returns to IDLE with all tokens, counters and `last_err` cleared.
  - HSSIM line buffers are not flushed; the next frame's first `PIPE_LATENCY` results rely on the HSSIM's own border handling.
- Reset values: `s_ready=0`, `hssim_stall=1`, `hssim_in_sel=1`, `m_valid=0`, `m_last=0`, `col_idx=0`, `row_idx=0`, `busy=0`, `frame_done=0`, `last_err=0`.

## Timing
- All outputs are combinational from registered state plus `s_valid`/`m_ready`; there is no input-to-output register stage.
- A beat accepted on advance k produces `m_valid` after exactly `PIPE_LATENCY` further advances, counting the advance that accepted it.
- Streaming throughput is 1 beat/cycle.
- Minimum frame time is `BEATS + PIPE_LATENCY + 1` cycles from `start` to `frame_done`.
- The cycle where `blocked` and `s_valid` are both high stalls; input is not consumed and the output is held.
- The `m_last` handshake and `frame_done` are on consecutive cycles.

## Configuration
- `HSSIM_CTRL_LAST_CHECK_EN` defined:
  - On each RUN `adv`, compare `s_last` with `(in_cnt==BEATS-1)`.
  - A mismatch sets `last_err`, which stays set until `reset`.
  - Sequencing is unaffected; `BEATS` always governs.
- Not defined: `s_last` is ignored and `last_err` is tied to 0.

## Test plan
All scenarios use `IMAGE_DIM=32`, `PIXELS_PER_BEAT=16` (`BEATS=64`) and `PIPE_LATENCY=4`.
- **Streaming**: `reset`, `start`, `s_valid=1`, `m_ready=1` held → `s_ready` high for 64 cycles; first `m_valid` 4 cycles after the first acceptance; exactly 64 `m_fire`; `m_last` on the 64th; `frame_done` the next cycle; `busy` then falls.
- **Backpressure**: `m_ready=0` for 10 cycles after the 20th result → `hssim_stall=1`, `s_ready=0`, `m_valid` held steady; still exactly 64 unique results; `out_cnt` ends at 64.
- **Input bubbles**: `s_valid` alternating 1/0 → `hssim_stall` equals `~s_valid` during RUN; `col_idx` wraps 1→0 and `row_idx` increments every 2 beats; 64 results.
- **Early `s_last`**: `s_last=1` on beat 30 → `last_err=1` from the next cycle and sticky; the frame still emits 64 results. With the macro undefined, `last_err` stays 0.
- **Reset mid-frame**: `reset` at beat 40 → next cycle shows all reset values; a following `start` yields a complete 64-result frame.
- **Start while busy**: `start` pulses during RUN and FLUSH are ignored; exactly one `frame_done`.
